mult_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that time-shares one `comb_multiplier` datapath between two requesters. It accepts operand pairs through a valid/ready handshake and drives the shared multiplier's operand inputs. After a fixed, parameterised settling time it captures the product and returns it to the granted requester as a one-cycle response pulse. It sits between the client logic and the multiplier instance.

---
 rtl/mult_share_arbiter.sv | 121 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin front end that time-shares one combinational multiplier
// between two requesters and returns each product as a one-cycle pulse.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   reqN_valid/a/b/ready  operand handshake for requester N (N = 0, 1)
//   rspN_valid/product    response pulse and held product for requester N
//   mul_a, mul_b          registered operands to the shared multiplier
//   mul_product           product returned by the shared multiplier
//   busy                  an operation is in flight
module mult_share_arbiter #(
    parameter int WIDTH   = 4,
    parameter int MUL_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               req1_ready,
    output logic               rsp0_valid,
    output logic [2*WIDTH-1:0] rsp0_product,
    output logic               rsp1_valid,
    output logic [2*WIDTH-1:0] rsp1_product,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               busy
);

    // MUL_LAT must be at least 1; the counter must hold MUL_LAT itself.
    localparam int CW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic          last_grant;
    logic          owner;
    logic          win0;
    logic          win1;
    logic          hs0;
    logic          hs1;
    logic          done;

    // Requester 1 takes a tie only when requester 0 was served last.
    assign win1 = req1_valid & (~req0_valid | ~last_grant);
    assign win0 = req0_valid & ~win1;

    assign hs0  = req0_valid & req0_ready;
    assign hs1  = req1_valid & req1_ready;
    assign done = (state == S_WAIT) && (cnt == CW'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (hs0 | hs1) state_nx = S_WAIT;
            S_WAIT: if (done)      state_nx = S_IDLE;
            default:               state_nx = S_IDLE;
        endcase
    end

    // Outputs; ready is held low while reset is asserted.
    always_comb begin
        req0_ready = rst_n & (state == S_IDLE) & win0;
        req1_ready = rst_n & (state == S_IDLE) & win1;
        busy       = (state == S_WAIT);
    end

    // Operand capture, settle counter and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp0_product <= '0;
            rsp1_product <= '0;
        end else begin
            rsp0_valid <= done & ~owner;
            rsp1_valid <= done & owner;
            if (hs0 | hs1) begin
                mul_a <= hs1 ? req1_a : req0_a;
                mul_b <= hs1 ? req1_b : req0_b;
                owner <= hs1;
                cnt   <= CW'(MUL_LAT);
            end else if (done) begin
                last_grant <= owner;
                if (owner) begin
                    rsp1_product <= mul_product;
                end else begin
                    rsp0_product <= mul_product;
                end
            end else if (state == S_WAIT) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: vector table plus hand-written
// sequences for fairness, idle hold, mid-operation reset and MUL_LAT=3.
module tb_mult_share_arbiter;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Instance with MUL_LAT = 1
    logic           v0 = 0, v1 = 0;
    logic [W-1:0]   a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic           r0, r1, o0v, o1v, bsy;
    logic [2*W-1:0] o0p, o1p, mp;
    logic [W-1:0]   ma, mb;

    // Instance with MUL_LAT = 3
    logic           q0v = 0, q1v = 0;
    logic [W-1:0]   qa0 = 0, qb0 = 0, qa1 = 0, qb1 = 0;
    logic           qr0, qr1, qo0v, qo1v, qbsy;
    logic [2*W-1:0] qo0p, qo1p, qmp;
    logic [W-1:0]   qma, qmb;

    // Shared multiplier models (combinational)
    assign mp  = {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
    assign qmp = {{W{1'b0}}, qma} * {{W{1'b0}}, qmb};

    always #5 clk = ~clk;

    mult_share_arbiter #(.WIDTH(W), .MUL_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_ready(r0),
        .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_ready(r1),
        .rsp0_valid(o0v), .rsp0_product(o0p),
        .rsp1_valid(o1v), .rsp1_product(o1p),
        .mul_a(ma), .mul_b(mb), .mul_product(mp), .busy(bsy)
    );

    mult_share_arbiter #(.WIDTH(W), .MUL_LAT(3)) u3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(q0v), .req0_a(qa0), .req0_b(qb0), .req0_ready(qr0),
        .req1_valid(q1v), .req1_a(qa1), .req1_b(qb1), .req1_ready(qr1),
        .rsp0_valid(qo0v), .rsp0_product(qo0p),
        .rsp1_valid(qo1v), .rsp1_product(qo1p),
        .mul_a(qma), .mul_b(qmb), .mul_product(qmp), .busy(qbsy)
    );

    typedef struct packed {
        logic           v0;
        logic [W-1:0]   a0, b0;
        logic           v1;
        logic [W-1:0]   a1, b1;
        logic           r0, r1;
        logic           o0v;
        logic [2*W-1:0] o0p;
        logic           o1v;
        logic [2*W-1:0] o1p;
        logic [W-1:0]   ma, mb;
        logic           bsy;
    } vec_t;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else
            passed++;
    endtask

    function automatic vec_t mk(
        input logic iv0, input logic [W-1:0] ia0, input logic [W-1:0] ib0,
        input logic iv1, input logic [W-1:0] ia1, input logic [W-1:0] ib1,
        input logic er0, input logic er1,
        input logic eo0v, input logic [2*W-1:0] eo0p,
        input logic eo1v, input logic [2*W-1:0] eo1p,
        input logic [W-1:0] ema, input logic [W-1:0] emb,
        input logic ebsy);
        vec_t t;
        t.v0 = iv0; t.a0 = ia0; t.b0 = ib0;
        t.v1 = iv1; t.a1 = ia1; t.b1 = ib1;
        t.r0 = er0; t.r1 = er1;
        t.o0v = eo0v; t.o0p = eo0p;
        t.o1v = eo1v; t.o1p = eo1p;
        t.ma = ema; t.mb = emb; t.bsy = ebsy;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clr_in();
        v0 = 0; v1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt [14];
        int   grants [6];
        int   ng;
        int   gap;
        int   pulses;

        // Row: inputs, then r0 r1 | rsp0 v,p | rsp1 v,p | mul a,b | busy
        vt[0]  = mk(1, 15, 15, 1, 7, 9,  1, 0, 0, 0,   0, 0,   0, 0, 0);
        vt[1]  = mk(0, 0, 0,   1, 7, 9,  0, 0, 0, 0,   0, 0,   15, 15, 1);
        vt[2]  = mk(0, 0, 0,   1, 7, 9,  0, 1, 1, 225, 0, 0,   15, 15, 0);
        vt[3]  = mk(0, 0, 0,   0, 0, 0,  0, 0, 0, 225, 0, 0,   7, 9, 1);
        vt[4]  = mk(0, 0, 0,   0, 0, 0,  0, 0, 0, 225, 1, 63,  7, 9, 0);
        vt[5]  = mk(1, 3, 2,   0, 0, 0,  1, 0, 0, 225, 0, 63,  7, 9, 0);
        vt[6]  = mk(0, 0, 0,   0, 0, 0,  0, 0, 0, 225, 0, 63,  3, 2, 1);
        vt[7]  = mk(0, 0, 0,   0, 0, 0,  0, 0, 1, 6,   0, 63,  3, 2, 0);
        vt[8]  = mk(0, 0, 0,   1, 8, 15, 0, 1, 0, 6,   0, 63,  3, 2, 0);
        vt[9]  = mk(0, 0, 0,   0, 0, 0,  0, 0, 0, 6,   0, 63,  8, 15, 1);
        vt[10] = mk(0, 0, 0,   0, 0, 0,  0, 0, 0, 6,   1, 120, 8, 15, 0);
        vt[11] = mk(1, 1, 1,   0, 0, 0,  1, 0, 0, 6,   0, 120, 8, 15, 0);
        vt[12] = mk(0, 0, 0,   0, 0, 0,  0, 0, 0, 6,   0, 120, 1, 1, 1);
        vt[13] = mk(0, 0, 0,   0, 0, 0,  0, 0, 1, 1,   0, 120, 1, 1, 0);

        // Reset state
        #2;
        chk("reset ready0", r0, 0);
        chk("reset ready1", r1, 0);
        chk("reset busy", bsy, 0);
        chk("reset mul_a", ma, 0);
        chk("reset rsp", {o0v, o1v}, 0);
        do_reset();

        // Vector table
        for (int i = 0; i < 14; i++) begin
            v0 = vt[i].v0; a0 = vt[i].a0; b0 = vt[i].b0;
            v1 = vt[i].v1; a1 = vt[i].a1; b1 = vt[i].b1;
            #1;
            chk($sformatf("row%0d ready0", i), r0, vt[i].r0);
            chk($sformatf("row%0d ready1", i), r1, vt[i].r1);
            chk($sformatf("row%0d rsp0_valid", i), o0v, vt[i].o0v);
            chk($sformatf("row%0d rsp0_product", i), o0p, vt[i].o0p);
            chk($sformatf("row%0d rsp1_valid", i), o1v, vt[i].o1v);
            chk($sformatf("row%0d rsp1_product", i), o1p, vt[i].o1p);
            chk($sformatf("row%0d mul_a", i), ma, vt[i].ma);
            chk($sformatf("row%0d mul_b", i), mb, vt[i].mb);
            chk($sformatf("row%0d busy", i), bsy, vt[i].bsy);
            step();
        end
        clr_in();

        // Round-robin fairness, both requesters always valid
        rst_n = 1'b0;
        v0 = 1; a0 = 2; b0 = 3;
        v1 = 1; a1 = 5; b1 = 4;
        step();
        chk("ready0 in reset", r0, 0);
        chk("ready1 in reset", r1, 0);
        rst_n = 1'b1;
        ng = 0;
        gap = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            #1;
            if (o0v) chk("rr rsp0_product", o0p, 6);
            if (o1v) chk("rr rsp1_product", o1p, 20);
            if (!bsy) begin
                gap++;
            end else if (gap > 0) begin
                chk("rr idle gap", gap, 1);
                gap = 0;
            end
            if (r0 && r1) chk("rr one ready", 2, 1);
            if (r0) begin
                grants[ng] = 0;
                ng++;
            end else if (r1) begin
                grants[ng] = 1;
                ng++;
            end
            @(posedge clk);
        end
        #1;
        chk("rr grant count", ng, 6);
        for (int i = 0; i < ng; i++)
            chk($sformatf("rr grant%0d", i), grants[i], i % 2);
        clr_in();
        repeat (3) step();

        // Idle hold: last operation was requester 1 with 5 x 4
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("idle%0d hold", i),
                {ma, mb, o0v, o1v, bsy}, {4'd5, 4'd4, 3'b000});
            step();
        end

        // Reset in the middle of an operation
        do_reset();
        v0 = 1; a0 = 3; b0 = 2;
        #1;
        chk("mid ready0", r0, 1);
        step();
        v0 = 0;
        step();
        chk("mid rsp0 before", {o0v, o0p}, {1'b1, 8'd6});
        v1 = 1; a1 = 5; b1 = 5;
        #1;
        chk("mid ready1", r1, 1);
        step();
        v1 = 0;
        chk("mid busy", bsy, 1);
        chk("mid mul_a", ma, 5);
        rst_n = 1'b0;
        #1;
        chk("mid rst mul", {ma, mb}, 0);
        chk("mid rst rsp0_product", o0p, 0);
        chk("mid rst busy", bsy, 0);
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            if (o1v) pulses++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (o1v) pulses++;
            step();
        end
        chk("mid no rsp1 pulse", pulses, 0);
        chk("mid rsp1_product", o1p, 0);
        v0 = 1; a0 = 1; b0 = 1;
        v1 = 1; a1 = 2; b1 = 2;
        #1;
        chk("mid tie ready0", r0, 1);
        chk("mid tie ready1", r1, 0);
        step();
        clr_in();
        repeat (3) step();

        // MUL_LAT = 3 instance
        q1v = 1; qa1 = 4; qb1 = 6;
        #1;
        chk("lat3 ready1", qr1, 1);
        step();
        q1v = 0;
        q0v = 1; qa0 = 9; qb0 = 9;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("lat3 wait%0d ready0", i), qr0, 0);
            chk($sformatf("lat3 wait%0d busy", i), qbsy, 1);
            chk($sformatf("lat3 wait%0d rsp1", i), qo1v, 0);
            step();
        end
        chk("lat3 rsp1_valid", qo1v, 1);
        chk("lat3 rsp1_product", qo1p, 24);
        chk("lat3 busy done", qbsy, 0);
        chk("lat3 ready0 after", qr0, 1);
        step();
        q0v = 0;
        chk("lat3 rsp1 pulse end", qo1v, 0);
        chk("lat3 rsp0 quiet", qo0v, 0);
        repeat (5) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
